// File: rtl/burst_check_ctrl_if.sv
// Burst request/grant bundle between requesters and burst_check_ctrl.
//   req[1:0]             per-requester burst request (held for the whole burst)
//   valid_in             data beat available from the granted requester
//   grant[1:0]           one-hot registered grant, 00 when idle
//   next_data_count[3:0] beat count presented to the capture flop
//   sel_a                capture from the check path (count 7 or 8)
//   load_en              capture-flop enable
//   busy                 controller not idle
//   done                 one-cycle burst completion pulse
//   abort                one-cycle burst abandon pulse
interface burst_check_ctrl_if;
   logic [1:0] req;
   logic       valid_in;
   logic [1:0] grant;
   logic [3:0] next_data_count;
   logic       sel_a;
   logic       load_en;
   logic       busy;
   logic       done;
   logic       abort;

   modport master (
      output req, valid_in,
      input  grant, next_data_count, sel_a, load_en, busy, done, abort
   );

   modport slave (
      input  req, valid_in,
      output grant, next_data_count, sel_a, load_en, busy, done, abort
   );
endinterface

// File: rtl/burst_check_ctrl.sv
// Two-requester round-robin burst controller. A granted burst collects seven
// data beats (count 0..6), then spends two check cycles (count 7, 8) capturing
// from the check path, then pulses done and returns to idle.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    burst_check_ctrl_if.slave (req/valid_in in, grant/status out)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no burst; arbitrate pending requests
// XFER  | collecting beats, count 0..6; dropped request aborts
// CHECK | check-path capture, count 7..8; request changes ignored
// DONE  | done pulse, record winner, release grant
module burst_check_ctrl (
   input  logic               clk,
   input  logic               reset,
   burst_check_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, XFER, CHECK, DONE} state_t;

   state_t     state, state_nxt;
   logic [3:0] count, count_nxt;
   logic [1:0] grant, grant_nxt;
   logic       last_winner, last_winner_nxt;
   logic       done, done_nxt;
   logic       abort, abort_nxt;
   logic       req_held;
   logic [1:0] winner;

   // Request of the currently granted requester still asserted.
   assign req_held = |(bus.req & grant);

   // Round-robin: on contention the requester that did not win last time wins.
   always_comb begin
      winner = bus.req;
      if (bus.req == 2'b11) begin
         winner = last_winner ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         count       <= 4'd0;
         grant       <= 2'b00;
         last_winner <= 1'b1;
         done        <= 1'b0;
         abort       <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         grant       <= grant_nxt;
         last_winner <= last_winner_nxt;
         done        <= done_nxt;
         abort       <= abort_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      count_nxt       = count;
      grant_nxt       = grant;
      last_winner_nxt = last_winner;
      done_nxt        = 1'b0;
      abort_nxt       = 1'b0;
      if (count > 4'd8) begin
         // Unreachable counts recover to a clean idle.
         state_nxt = IDLE;
         count_nxt = 4'd0;
         grant_nxt = 2'b00;
      end else begin
         case (state)
            IDLE: begin
               count_nxt = 4'd0;
               if (bus.req != 2'b00) begin
                  grant_nxt = winner;
                  state_nxt = XFER;
               end
            end
            XFER: begin
               if (!req_held) begin
                  // Abort wins over a coincident beat; last_winner untouched.
                  state_nxt = IDLE;
                  grant_nxt = 2'b00;
                  count_nxt = 4'd0;
                  abort_nxt = 1'b1;
               end else if (bus.valid_in) begin
                  count_nxt = count + 4'd1;
                  if (count == 4'd6) begin
                     state_nxt = CHECK;
                  end
               end
            end
            CHECK: begin
               if (count == 4'd8) begin
                  state_nxt = DONE;
                  count_nxt = 4'd0;
                  done_nxt  = 1'b1;
               end else begin
                  count_nxt = count + 4'd1;
               end
            end
            DONE: begin
               last_winner_nxt = grant[1];
               grant_nxt       = 2'b00;
               state_nxt       = IDLE;
            end
            default: begin
               state_nxt = IDLE;
               count_nxt = 4'd0;
               grant_nxt = 2'b00;
            end
         endcase
      end
   end

   assign bus.grant           = grant;
   assign bus.next_data_count = count;
   assign bus.sel_a           = (count == 4'd7) || (count == 4'd8);
   assign bus.load_en         = ((state == XFER) && bus.valid_in && req_held) ||
                                (state == CHECK);
   assign bus.busy            = (state != IDLE);
   assign bus.done            = done;
   assign bus.abort           = abort;

endmodule

// File: tb/tb_burst_check_ctrl.sv
module tb_burst_check_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;

   burst_check_ctrl_if bus ();

   burst_check_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: who owns the bus, how many beats have been taken,
   // and how far into the post-beat tail (check, check, done) we are.
   int m_owner = -1;
   int m_beats = 0;
   int m_tail  = 0;
   int m_last  = 1;
   bit m_abort = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input logic [1:0] rq, input bit v);
      if (r) begin
         m_owner = -1; m_beats = 0; m_tail = 0; m_last = 1; m_abort = 1'b0;
      end else begin
         m_abort = 1'b0;
         if (m_owner < 0) begin
            if (rq != 2'b00) begin
               if (rq == 2'b11) m_owner = (m_last == 0) ? 1 : 0;
               else             m_owner = (rq == 2'b01) ? 0 : 1;
               m_beats = 0;
               m_tail  = 0;
            end
         end else if (m_beats < 7) begin
            if (rq[m_owner] == 1'b0) begin
               m_owner = -1; m_beats = 0; m_abort = 1'b1;
            end else if (v) begin
               m_beats++;
               m_tail = 0;
            end
         end else if (m_tail < 2) begin
            m_tail++;
         end else begin
            m_last  = m_owner;
            m_owner = -1;
            m_beats = 0;
            m_tail  = 0;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [1:0] e_grant;
      int         e_cnt;
      bit         in_check, e_done, e_load;
      e_grant  = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
      in_check = (m_owner >= 0) && (m_beats == 7) && (m_tail < 2);
      e_done   = (m_owner >= 0) && (m_beats == 7) && (m_tail == 2);
      if (m_owner < 0)       e_cnt = 0;
      else if (m_beats < 7)  e_cnt = m_beats;
      else if (m_tail == 0)  e_cnt = 7;
      else if (m_tail == 1)  e_cnt = 8;
      else                   e_cnt = 0;
      e_load = in_check ||
               ((m_owner >= 0) && (m_beats < 7) && bus.valid_in && bus.req[m_owner]);
      chk({tag, ".grant"}, 32'(bus.grant), 32'(e_grant));
      chk({tag, ".count"}, 32'(bus.next_data_count), 32'(e_cnt));
      chk({tag, ".sel_a"}, 32'(bus.sel_a), 32'(in_check));
      chk({tag, ".load_en"}, 32'(bus.load_en), 32'(e_load));
      chk({tag, ".busy"}, 32'(bus.busy), 32'(m_owner >= 0));
      chk({tag, ".done"}, 32'(bus.done), 32'(e_done));
      chk({tag, ".abort"}, 32'(bus.abort), 32'(m_abort));
   endtask

   task automatic step(input bit r, input logic [1:0] rq, input bit v, input string tag);
      reset        = r;
      bus.req      = rq;
      bus.valid_in = v;
      @(posedge clk);
      model_edge(r, rq, v);
      @(negedge clk);
      check_outputs(tag);
   endtask

   initial begin
      bus.req      = 2'b00;
      bus.valid_in = 1'b0;

      // Reset state
      step(1, 2'b00, 0, "rst");
      step(1, 2'b11, 1, "rst_dom");

      // Single full burst, requester 0, valid held
      for (int i = 1; i <= 11; i++) begin
         step(0, 2'b01, 1, "burst0");
         if (i == 1)  chk("burst0.first_grant", 32'(bus.grant), 32'h1);
         if (i == 8)  chk("burst0.count7", 32'(bus.next_data_count), 32'd7);
         if (i == 9)  chk("burst0.count8", 32'(bus.next_data_count), 32'd8);
         if (i == 10) chk("burst0.done", 32'(bus.done), 32'h1);
         if (i == 11) chk("burst0.idle", 32'(bus.busy), 32'h0);
      end
      step(0, 2'b00, 0, "burst0.rel");

      // Round-robin across three bursts with both requests held
      step(1, 2'b00, 0, "rr.rst");
      for (int i = 1; i <= 33; i++) begin
         step(0, 2'b11, 1, "rr");
         if (i == 1)  chk("rr.grant1", 32'(bus.grant), 32'h1);
         if (i == 12) chk("rr.grant2", 32'(bus.grant), 32'h2);
         if (i == 23) chk("rr.grant3", 32'(bus.grant), 32'h1);
      end

      // Toggling valid_in
      step(1, 2'b00, 0, "tog.rst");
      for (int i = 0; i < 20; i++) step(0, 2'b01, (i % 2) == 0, "tog");

      // Abort at count 3, then contention re-grants requester 0
      step(1, 2'b00, 0, "abt.rst");
      for (int i = 0; i < 4; i++) step(0, 2'b01, 1, "abt.fill");
      step(0, 2'b00, 1, "abt");
      chk("abt.pulse", 32'(bus.abort), 32'h1);
      chk("abt.grant", 32'(bus.grant), 32'h0);
      step(0, 2'b11, 1, "abt.regrant");
      chk("abt.regrant01", 32'(bus.grant), 32'h1);
      step(0, 2'b11, 0, "abt.after");

      // Request dropped during CHECK completes normally
      step(1, 2'b00, 0, "chkdrop.rst");
      for (int i = 0; i < 8; i++) step(0, 2'b01, 1, "chkdrop.fill");
      step(0, 2'b00, 0, "chkdrop.c8");
      step(0, 2'b00, 0, "chkdrop.done");
      chk("chkdrop.done_pulse", 32'(bus.done), 32'h1);
      step(0, 2'b00, 0, "chkdrop.idle");

      // Reset at count 7
      step(1, 2'b00, 0, "rst7.rst");
      for (int i = 0; i < 8; i++) step(0, 2'b10, 1, "rst7.fill");
      chk("rst7.at7", 32'(bus.next_data_count), 32'd7);
      step(1, 2'b10, 1, "rst7");
      chk("rst7.count0", 32'(bus.next_data_count), 32'd0);

      // Random traffic against the model
      begin
         logic [1:0] rq;
         rq = 2'b00;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7, 0) == 0) rq = 2'($urandom_range(3, 0));
            step($urandom_range(59, 0) == 0, rq, 1'($urandom_range(3, 0) != 0), "rand");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/burst_check_ctrl.md
BURST_CHECK_CTRL -- requirements
Module: burst_check_ctrl

Interface
REQ-001 SHALL have no parameters; word width is fixed at 32 bits and the count width at 4 bits.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 req  input  2  per-requester burst request, held high for the whole burst.
REQ-006 valid_in  input  1  data beat available from the granted requester.
REQ-007 grant  output  2  one-hot grant, registered; 00 when idle.
REQ-008 next_data_count  output  4  beat count presented to the 32-bit capture flop.
REQ-009 sel_a  output  1  high when next_data_count is 7 or 8 (capture from check path).
REQ-010 load_en  output  1  capture-flop enable.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse on burst completion.
REQ-013 abort  output  1  one-cycle pulse when a burst is abandoned.

Function
REQ-014 SHALL implement the registered FSM states IDLE, XFER, CHECK and DONE.
REQ-015 IDLE: count=0; if req!=00, grant<=winner, state<=XFER at the next edge.
REQ-016 Arbitration SHALL be round-robin: with both requests high, the requester other than last_winner wins; a single request wins outright.
REQ-017 XFER: if req[granted]==0 -> state<=IDLE, grant<=00, count<=0, abort<=1 for one cycle; abort takes priority over valid_in.
REQ-018 XFER: otherwise, valid_in=1 -> count<=count+1; on a beat with count==6 -> state<=CHECK (count becomes 7).
REQ-019 XFER: valid_in=0 -> count holds, no timeout.
REQ-020 CHECK: count<=count+1 unconditionally each cycle; at count==8 -> state<=DONE, count<=0; req changes are ignored.
REQ-021 DONE: done=1, last_winner<=granted index, grant<=00, state<=IDLE; there is no arbitration in DONE (earliest regrant is the edge after IDLE is entered).
REQ-022 next_data_count SHALL equal the count register: 0-6 in XFER, 7-8 in CHECK, 0 elsewhere.
REQ-023 sel_a SHALL be (next_data_count==7 || next_data_count==8), i.e. high only during CHECK.
REQ-024 load_en SHALL be (state==XFER && valid_in && req[granted]) || state==CHECK; this is the only combinational path from inputs.
REQ-025 Count SHALL never exceed 8; values 9-15 are unreachable and SHALL force IDLE with count=0 if ever present.
REQ-026 An aborted burst SHALL leave last_winner unchanged.

Reset
REQ-027 reset=1 at an edge SHALL set state=IDLE, count=0, grant=00, done=0, abort=0 and last_winner=1 (so req[0] wins the first contention).
REQ-028 Reset SHALL dominate all other inputs, including when it is asserted mid-burst in any state.

Verification
REQ-029 Reset, then req=01 with valid_in=1 held -> grant=01 after edge 1; count 0..6 on edges 1-7; count 7 and 8 with sel_a=1 on edges 8-9; done=1 after edge 10; grant=00 and busy=0 after edge 11.
REQ-030 req=11 held across three bursts -> grant sequence 01, 10, 01.
REQ-031 req=01, valid_in toggling 1,0,1,0 -> count advances only on valid cycles; load_en follows valid_in in XFER.
REQ-032 req[0] dropped at count=3 -> abort pulse for one cycle, grant=00, count=0; a following req=11 grants 01 again.
REQ-033 req[0] dropped during CHECK -> burst completes normally (count 8, done pulse) with no abort.
REQ-034 reset asserted while count=7 -> after the edge, all outputs are at reset values and next_data_count=0.
